// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared status codes, key codes, sequencer states and helpers
// Contents:
//   ST_ERR/ST_BUSY/ST_READY : calc_status encodings (2'b11 is reserved and behaves as BUSY)
//   K_*                     : keypad codes with a fixed meaning
//   seq_state_t             : sequencer FSM states
//   sat_add                 : 8-bit saturating add used by the event counters
package calc_pkg;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_MUL = 4'hC;
    localparam logic [3:0] K_NOP = 4'hD;
    localparam logic [3:0] K_EQ  = 4'hE;
    localparam logic [3:0] K_BSP = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_READY,
        RECOVER
    } seq_state_t;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - small synchronous FIFO with flush and fill-level output
// Ports:
//   clock, reset      : clock, asynchronous active-high reset
//   push, push_data   : write request and data (ignored when full unless popping)
//   pop               : read request (ignored when empty); pop_data is the head entry
//   flush             : empties the FIFO; wins over push and pop in the same cycle
//   full, empty, level: occupancy flags and entry count
module cmd_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;

endmodule

// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - keystroke buffer and command handshake sequencer for the calculator datapath
// Ports:
//   clock, reset            : clock, asynchronous active-high reset
//   key_valid/key_code/key_ready : keystroke input handshake
//   calc_status             : datapath status (00 ERROR, 01 BUSY, 10 READY, 11 as BUSY)
//   calc_cmd                : command to datapath, NOP_CMD when idle
//   calc_rst                : datapath reset pulse, high while recovering
//   seq_busy                : work pending (FIFO non-empty or FSM active)
//   err_count, drop_count   : saturating recovery and flushed-keystroke counters
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         HOLD_CYC   = 2,
    parameter int         TIMEOUT    = 1024,
    parameter int         RST_CYC    = 4,
    parameter logic [3:0] NOP_CMD    = 4'hD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [1:0] calc_status,
    output logic [3:0] calc_cmd,
    output logic       calc_rst,
    output logic       seq_busy,
    output logic [7:0] err_count,
    output logic [7:0] drop_count
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t    state;
    seq_state_t    nxt_state;
    logic [3:0]    cur_cmd;
    logic [TW-1:0] state_cyc;
    logic          enter_recover;
    logic          handshake;
    logic          push;
    logic          pop;
    logic [3:0]    head;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;

    // Codes that would look like "no command" on the datapath bus are dropped at the door.
    assign push = key_valid && key_ready && (key_code != K_NOP) && (key_code != NOP_CMD);
    assign pop  = (state == IDLE) && !empty && (calc_status == ST_READY);

    cmd_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (key_code),
        .pop       (pop),
        .flush     (enter_recover),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign handshake = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_READY);

    // state_cyc counts cycles spent in the current state; it serves as hold timer,
    // handshake watchdog and reset-pulse timer depending on the state.
    always_comb begin
        nxt_state     = state;
        enter_recover = 1'b0;
        case (state)
            IDLE:       if (pop) nxt_state = ISSUE;
            ISSUE:      if (state_cyc == TW'(HOLD_CYC - 1)) nxt_state = WAIT_BUSY;
            WAIT_BUSY:  if (calc_status == ST_BUSY || calc_status == 2'b11) nxt_state = WAIT_READY;
            WAIT_READY: if (calc_status == ST_READY) nxt_state = IDLE;
            RECOVER:    if (state_cyc == TW'(RST_CYC - 1)) nxt_state = IDLE;
            default:    nxt_state = RECOVER;
        endcase
        // Error and watchdog expiry override any normal handshake progress.
        if (handshake && (calc_status == ST_ERR || state_cyc == TW'(TIMEOUT - 1))) begin
            nxt_state     = RECOVER;
            enter_recover = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RECOVER;
            state_cyc  <= '0;
            cur_cmd    <= NOP_CMD;
            err_count  <= 8'h00;
            drop_count <= 8'h00;
        end else begin
            state <= nxt_state;
            if (nxt_state != state || state == IDLE) state_cyc <= '0;
            else                                     state_cyc <= state_cyc + 1'b1;
            if (pop) cur_cmd <= head;
            if (enter_recover) begin
                err_count  <= sat_add(err_count, 8'h01);
                // A key accepted on the entry edge is flushed with the rest.
                drop_count <= sat_add(drop_count, 8'(level) + 8'(push));
            end
        end
    end

    assign key_ready = !full && (state != RECOVER);
    assign calc_cmd  = (state == ISSUE || state == WAIT_BUSY) ? cur_cmd : NOP_CMD;
    assign calc_rst  = (state == RECOVER);
    assign seq_busy  = !empty || (state != IDLE);

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb/tb_calc_cmd_sequencer.sv - self-checking bench with datapath model and command scoreboard
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int         HOLD = 2;
    localparam int         TMO  = 1024;
    localparam int         RSTC = 4;
    localparam logic [3:0] NOP  = 4'hD;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic [1:0] calc_status = ST_READY;
    logic [3:0] calc_cmd;
    logic       calc_rst;
    logic       seq_busy;
    logic [7:0] err_count;
    logic [7:0] drop_count;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [3:0] exp_q [$];
    int         mode = 1;      // 0: model answers handshakes, 1: bench drives calc_status
    int         issued = 0;

    calc_cmd_sequencer #(
        .FIFO_DEPTH (4),
        .HOLD_CYC   (HOLD),
        .TIMEOUT    (TMO),
        .RST_CYC    (RSTC),
        .NOP_CMD    (NOP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .calc_status (calc_status),
        .calc_cmd    (calc_cmd),
        .calc_rst    (calc_rst),
        .seq_busy    (seq_busy),
        .err_count   (err_count),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic try_key(input logic [3:0] c, input int maxc, output logic ok);
        key_code  = c;
        key_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (key_ready) ok = 1'b1;
            tick(1);
        end
        key_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input logic expect_issue);
        logic ok;
        if (expect_issue) exp_q.push_back(c);
        try_key(c, 50, ok);
        check("key_accepted", 32'(ok), 32'd1);
    endtask

    task automatic pulse_len(output int n);
        n = 0;
        for (int i = 0; i < 20 && calc_rst; i++) begin
            n++;
            tick(1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !seq_busy && calc_status == ST_READY) break;
            tick(1);
        end
        check("drain_done", 32'(exp_q.size() == 0 && !seq_busy), 32'd1);
    endtask

    task automatic do_reset();
        int n;
        mode        = 1;
        calc_status = ST_READY;
        key_valid   = 1'b0;
        reset       = 1'b1;
        #2;
        check("rst_calc_cmd", 32'(calc_cmd), 32'(NOP));
        check("rst_calc_rst", 32'(calc_rst), 32'd1);
        check("rst_seq_busy", 32'(seq_busy), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        tick(1);
        reset = 1'b0;
        pulse_len(n);
        check("rst_pulse_len", 32'(n), 32'(RSTC));
        check("post_rst_key_ready", 32'(key_ready), 32'd1);
        check("post_rst_seq_busy", 32'(seq_busy), 32'd0);
        check("post_rst_calc_cmd", 32'(calc_cmd), 32'(NOP));
    endtask

    // Datapath model: scoreboards every new command and, in mode 0, acknowledges it
    // with BUSY for 3 cycles once it has been held HOLD cycles.
    initial begin : model
        logic       in_cmd;
        int         hold;
        int         bcnt;
        logic [3:0] front;
        in_cmd = 1'b0;
        hold   = 0;
        bcnt   = 0;
        forever begin
            @(posedge clock);
            #1;
            if (calc_cmd !== NOP) begin
                if (!in_cmd) begin
                    in_cmd = 1'b1;
                    hold   = 0;
                    issued++;
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_cmd", 32'(calc_cmd), 32'(NOP));
                    end else begin
                        front = exp_q.pop_front();
                        check("sb_cmd", 32'(calc_cmd), 32'(front));
                    end
                end
                hold++;
            end else if (in_cmd) begin
                in_cmd = 1'b0;
                check("cmd_hold_cycles", 32'(hold >= HOLD), 32'd1);
            end
            if (mode == 0) begin
                if (bcnt > 0) begin
                    bcnt--;
                    calc_status = (bcnt == 0) ? ST_READY : ST_BUSY;
                end else if (in_cmd && hold == HOLD) begin
                    calc_status = ST_BUSY;
                    bcnt        = 3;
                end else begin
                    calc_status = ST_READY;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic ok;
        int   n;
        #1;
        // Reset values and the power-on datapath reset pulse.
        do_reset();

        // Normal operation: four commands issued in order.
        mode   = 0;
        issued = 0;
        send(4'h3, 1'b1);
        send(K_ADD, 1'b1);
        send(4'h4, 1'b1);
        send(K_EQ, 1'b1);
        drain();
        check("t1_issued", 32'(issued), 32'd4);
        check("t1_err_count", 32'(err_count), 32'd0);

        // Fill while datapath BUSY: 5th key refused, nothing issued until READY.
        mode        = 1;
        calc_status = ST_BUSY;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        check("t2_ready_before_full", 32'(key_ready), 32'd1);
        send(4'h5, 1'b0);
        check("t2_ready_when_full", 32'(key_ready), 32'd0);
        try_key(4'h6, 5, ok);
        check("t2_fifth_refused", 32'(ok), 32'd0);
        check("t2_no_issue_busy", 32'(calc_cmd), 32'(NOP));
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h5);
        issued = 0;
        mode   = 0;
        drain();
        check("t2_issued", 32'(issued), 32'd4);

        // ERROR in WAIT_BUSY with two keys still queued.
        mode        = 1;
        calc_status = ST_READY;
        send(4'h7, 1'b1);
        send(4'h8, 1'b0);
        send(4'h9, 1'b0);
        tick(2);
        check("t3_cmd_in_wait_busy", 32'(calc_cmd), 32'h7);
        calc_status = ST_ERR;
        tick(1);
        calc_status = ST_READY;
        pulse_len(n);
        check("t3_rst_pulse_len", 32'(n), 32'(RSTC));
        check("t3_drop_count", 32'(drop_count), 32'd2);
        check("t3_err_count", 32'(err_count), 32'd1);
        check("t3_idle_calc_cmd", 32'(calc_cmd), 32'(NOP));
        check("t3_idle_seq_busy", 32'(seq_busy), 32'd0);

        // Handshake timeout: datapath stays READY and never goes BUSY.
        do_reset();
        send(4'h6, 1'b1);
        for (int i = 0; i < 10 && calc_cmd === NOP; i++) tick(1);
        n = 0;
        for (int i = 0; i < 1200 && !calc_rst; i++) begin
            tick(1);
            n++;
        end
        check("t4_cycles_to_recover", 32'(n), 32'(HOLD + TMO));
        check("t4_err_count", 32'(err_count), 32'd1);
        check("t4_drop_count", 32'(drop_count), 32'd0);
        pulse_len(n);
        check("t4_rst_pulse_len", 32'(n), 32'(RSTC));

        // NOP code offered between digits is discarded without counting as a drop.
        mode   = 0;
        issued = 0;
        send(4'h1, 1'b1);
        send(K_NOP, 1'b0);
        send(4'h2, 1'b1);
        drain();
        check("t5_issued", 32'(issued), 32'd2);
        check("t5_drop_count", 32'(drop_count), 32'd0);

        // Asynchronous reset while in WAIT_READY with one key still queued.
        mode        = 1;
        calc_status = ST_READY;
        send(4'h2, 1'b1);
        send(4'h5, 1'b0);
        tick(2);
        calc_status = ST_BUSY;
        tick(1);
        check("t6_wait_ready_cmd", 32'(calc_cmd), 32'(NOP));
        check("t6_wait_ready_busy", 32'(seq_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_calc_rst", 32'(calc_rst), 32'd1);
        check("t6_async_calc_cmd", 32'(calc_cmd), 32'(NOP));
        check("t6_async_err_count", 32'(err_count), 32'd0);
        check("t6_async_seq_busy", 32'(seq_busy), 32'd1);
        calc_status = ST_READY;
        tick(1);
        reset = 1'b0;
        pulse_len(n);
        check("t6_rst_pulse_len", 32'(n), 32'(RSTC));
        check("t6_fifo_empty", 32'(seq_busy), 32'd0);
        issued = 0;
        tick(8);
        check("t6_nothing_issued", 32'(issued), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
